// File: rtl/lcd_pkg.sv
// lcd_pkg: controller states, HD44780 command bytes and timer width
// shared by write_lcd_block (WRITE_LCD_INIT_EN enables power-up init)
`timescale 1ns/1ps
package lcd_pkg;

  typedef enum logic [2:0] {
    POWERUP,
    INIT,
    IDLE,
    SETUP,
    EHIGH,
    HOLD,
    WAIT
  } lcd_state_e;

  localparam logic [7:0] CMD_FUNC  = 8'h38;
  localparam logic [7:0] CMD_DISP  = 8'h0C;
  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_ENTRY = 8'h06;
  localparam logic [7:0] CMD_LINE1 = 8'h80;
  localparam logic [7:0] CMD_LINE2 = 8'hC0;

  localparam int CNT_W = 20;

  function automatic logic [7:0] init_cmd(
    input logic [1:0] idx
  );
    logic [7:0] c;
    unique case (idx)
      2'd0:    c = CMD_FUNC;
      2'd1:    c = CMD_DISP;
      2'd2:    c = CMD_CLEAR;
      default: c = CMD_ENTRY;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/lcd_bus_cycle.sv
// lcd_bus_cycle: one LCD write transaction SETUP/EHIGH/HOLD/WAIT
// done_o pulses on the last WAIT cycle; start_i is accepted then or in IDLE
`timescale 1ns/1ps
module lcd_bus_cycle
  import lcd_pkg::*;
#(
  parameter int T_SETUP = 2,
  parameter int T_EPW   = 12,
  parameter int T_HOLD  = 2,
  parameter int T_EXEC  = 2000,
  parameter int T_CLEAR = 82000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic       rs_i,
  input  logic [7:0] data_i,
  output logic       done_o,
  output logic       e_o,
  output logic       rs_o,
  output logic [7:0] data_o
);

  lcd_state_e       ph_q, ph_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] wait_last;
  logic             e_q, e_d;
  logic             rs_q, rs_d;
  logic             clr_q, clr_d;
  logic [7:0]       dat_q, dat_d;

  assign wait_last = clr_q ? CNT_W'(T_CLEAR - 1)
                           : CNT_W'(T_EXEC - 1);
  assign done_o = (ph_q == WAIT) && (cnt_q == wait_last);
  assign e_o    = e_q;
  assign rs_o   = rs_q;
  assign data_o = dat_q;

  always_comb begin
    ph_d  = ph_q;
    cnt_d = cnt_q + 1'b1;
    e_d   = e_q;
    rs_d  = rs_q;
    dat_d = dat_q;
    clr_d = clr_q;
    unique case (ph_q)
      SETUP: if (cnt_q == CNT_W'(T_SETUP - 1)) begin
        ph_d  = EHIGH;
        e_d   = 1'b1;
        cnt_d = '0;
      end
      EHIGH: if (cnt_q == CNT_W'(T_EPW - 1)) begin
        ph_d  = HOLD;
        e_d   = 1'b0;
        cnt_d = '0;
      end
      HOLD: if (cnt_q == CNT_W'(T_HOLD - 1)) begin
        ph_d  = WAIT;
        cnt_d = '0;
      end
      WAIT: if (done_o) begin
        ph_d  = IDLE;
        cnt_d = '0;
      end
      default: begin
        ph_d  = IDLE;
        cnt_d = '0;
      end
    endcase
    // back-to-back: a new write may launch on the final WAIT cycle
    if (start_i && (ph_q == IDLE || done_o)) begin
      ph_d  = SETUP;
      cnt_d = '0;
      rs_d  = rs_i;
      dat_d = data_i;
      clr_d = !rs_i && (data_i == CMD_CLEAR);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_q  <= IDLE;
      cnt_q <= '0;
      e_q   <= 1'b0;
      rs_q  <= 1'b0;
      clr_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ph_q  <= ph_d;
      cnt_q <= cnt_d;
      e_q   <= e_d;
      rs_q  <= rs_d;
      clr_q <= clr_d;
      dat_q <= dat_d;
    end
  end

endmodule

// File: rtl/write_lcd_block.sv
// write_lcd_block: button-driven HD44780 character writer with cursor wrap
// WRITE_LCD_INIT_EN adds the power-up wait and 38/0C/01/06 init sequence
`timescale 1ns/1ps
module write_lcd_block
  import lcd_pkg::*;
#(
  parameter int T_SETUP   = 2,
  parameter int T_EPW     = 12,
  parameter int T_HOLD    = 2,
  parameter int T_EXEC    = 2000,
  parameter int T_CLEAR   = 82000,
  parameter int T_POWERUP = 750000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] data_btn,
  input  logic       prell_flag,
  output logic       RW_btn_lcd,
  output logic       RS_btn_lcd,
  output logic       E_btn_lcd,
  output logic [7:0] data_btn_lcd
);

  lcd_state_e st_q, st_d;
  logic       prell_q, rise;
  logic       pend_q, pend_d;
  logic [7:0] pbyte_q, pbyte_d;
  logic       chr_q, chr_d;
  logic [7:0] char_q, char_d;
  logic [4:0] cur_q, cur_d;
  logic       wrap_q, wrap_d;
  logic       start, st_rs, done;
  logic [7:0] st_data;
  logic       try_serve, serve, rise_used, adv;
  logic [7:0] sbyte;
`ifdef WRITE_LCD_INIT_EN
  logic [CNT_W-1:0] pu_q, pu_d;
  logic [2:0]       idx_q, idx_d;
`else
  logic unused_cfg;
  assign unused_cfg = (T_POWERUP > 0);
`endif

  assign rise       = prell_flag & ~prell_q;
  assign RW_btn_lcd = 1'b0;

  always_comb begin
    st_d      = st_q;
    pend_d    = pend_q;
    pbyte_d   = pbyte_q;
    chr_d     = chr_q;
    char_d    = char_q;
    cur_d     = cur_q;
    wrap_d    = wrap_q;
    start     = 1'b0;
    st_rs     = 1'b0;
    st_data   = '0;
    try_serve = 1'b0;
    serve     = 1'b0;
    sbyte     = '0;
    rise_used = 1'b0;
    adv       = 1'b0;
`ifdef WRITE_LCD_INIT_EN
    pu_d  = pu_q;
    idx_d = idx_q;
`endif
    unique case (st_q)
      POWERUP: begin
`ifdef WRITE_LCD_INIT_EN
        pu_d = pu_q + 1'b1;
        if (pu_q == CNT_W'(T_POWERUP - 1)) begin
          st_d    = INIT;
          start   = 1'b1;
          st_data = init_cmd(2'd0);
          idx_d   = 3'd1;
        end
`else
        st_d = IDLE;
`endif
      end
`ifdef WRITE_LCD_INIT_EN
      INIT: if (done) begin
        if (idx_q == 3'd4) begin
          st_d      = IDLE;
          try_serve = 1'b1;
        end else begin
          start   = 1'b1;
          st_data = init_cmd(idx_q[1:0]);
          idx_d   = idx_q + 3'd1;
        end
      end
`endif
      IDLE: try_serve = 1'b1;
      WAIT: if (done) begin
        if (chr_q) begin
          start   = 1'b1;
          st_rs   = 1'b1;
          st_data = char_q;
          chr_d   = 1'b0;
          adv     = 1'b1;
        end else begin
          st_d      = IDLE;
          try_serve = 1'b1;
        end
      end
      default: st_d = IDLE;
    endcase

    if (try_serve) begin
      if (pend_q) begin
        serve  = 1'b1;
        sbyte  = pbyte_q;
        pend_d = 1'b0;
      end else if (rise) begin
        serve     = 1'b1;
        sbyte     = data_btn;
        rise_used = 1'b1;
      end
    end

    // line start positions need an address command before the char
    if (serve) begin
      start = 1'b1;
      st_d  = WAIT;
      if (cur_q == 5'd16 || (cur_q == 5'd0 && wrap_q)) begin
        st_data = cur_q[4] ? CMD_LINE2 : CMD_LINE1;
        chr_d   = 1'b1;
        char_d  = sbyte;
      end else begin
        st_rs   = 1'b1;
        st_data = sbyte;
        adv     = 1'b1;
      end
    end

    if (adv) begin
      cur_d = cur_q + 5'd1;
      if (cur_q == 5'd31) wrap_d = 1'b1;
    end

    if (rise && !rise_used && !pend_d) begin
      pend_d  = 1'b1;
      pbyte_d = data_btn;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q    <= POWERUP;
      prell_q <= 1'b0;
      pend_q  <= 1'b0;
      pbyte_q <= '0;
      chr_q   <= 1'b0;
      char_q  <= '0;
      cur_q   <= '0;
      wrap_q  <= 1'b0;
`ifdef WRITE_LCD_INIT_EN
      pu_q    <= '0;
      idx_q   <= '0;
`endif
    end else begin
      st_q    <= st_d;
      prell_q <= prell_flag;
      pend_q  <= pend_d;
      pbyte_q <= pbyte_d;
      chr_q   <= chr_d;
      char_q  <= char_d;
      cur_q   <= cur_d;
      wrap_q  <= wrap_d;
`ifdef WRITE_LCD_INIT_EN
      pu_q    <= pu_d;
      idx_q   <= idx_d;
`endif
    end
  end

  lcd_bus_cycle #(
    .T_SETUP (T_SETUP),
    .T_EPW   (T_EPW),
    .T_HOLD  (T_HOLD),
    .T_EXEC  (T_EXEC),
    .T_CLEAR (T_CLEAR)
  ) u_bus (
    .clk     (clk),
    .rst_n   (reset_n),
    .start_i (start),
    .rs_i    (st_rs),
    .data_i  (st_data),
    .done_o  (done),
    .e_o     (E_btn_lcd),
    .rs_o    (RS_btn_lcd),
    .data_o  (data_btn_lcd)
  );

endmodule

// File: tb/tb_write_lcd_block.sv
// tb_write_lcd_block: randomized bench with an E-pulse monitor and
// a cursor/address reference model (works with or without WRITE_LCD_INIT_EN)
`timescale 1ns/1ps
module tb_write_lcd_block;

  localparam int TS = 2;
  localparam int TE = 12;
  localparam int TH = 2;
  localparam int TX = 20;
  localparam int TC = 40;
  localparam int TP = 100;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       prell = 1'b0;
  logic [7:0] dbtn = 8'h00;
  logic       rw, rs, e;
  logic [7:0] dout;

  always #5 clk = ~clk;

  write_lcd_block #(
    .T_SETUP(TS), .T_EPW(TE), .T_HOLD(TH),
    .T_EXEC(TX), .T_CLEAR(TC), .T_POWERUP(TP)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .data_btn     (dbtn),
    .prell_flag   (prell),
    .RW_btn_lcd   (rw),
    .RS_btn_lcd   (rs),
    .E_btn_lcd    (e),
    .data_btn_lcd (dout)
  );

  typedef struct {
    logic       rs;
    logic [7:0] d;
    int         width;
    int         setup;
    int         rise;
    int         fall;
  } wr_t;

  wr_t        obs[$];
  logic       exp_rs[$];
  logic [7:0] exp_d[$];
  int         m_cnt = 0;
  bit         m_wrap = 0;
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         prot_err = 0;
  int         rel_cyc = 0;

  // bus monitor: records every complete E pulse, flags protocol breaks
  logic       e_prev = 1'b0;
  logic [8:0] last_bus = '0;
  int         stab = 1;
  int         last_fall = -100;
  bit         in_p = 0;
  wr_t        cur;
  always @(negedge clk) begin
    bit chg;
    cyc++;
    if (!reset_n) begin
      e_prev = 1'b0; in_p = 0; stab = 1;
      last_bus = {rs, dout}; last_fall = -100;
    end else begin
      if (rw !== 1'b0) prot_err++;
      chg = ({rs, dout} != last_bus);
      if (chg) begin last_bus = {rs, dout}; stab = 1; end
      else stab++;
      if (e && !e_prev) begin
        cur.rs = rs; cur.d = dout; cur.setup = stab - 1;
        cur.rise = cyc; cur.width = 1; in_p = 1;
      end else if (e && in_p) begin
        cur.width++;
      end else if (!e && e_prev && in_p) begin
        cur.fall = cyc; obs.push_back(cur);
        in_p = 0; last_fall = cyc;
      end
      if (chg && (e || (cyc - last_fall < TH))) prot_err++;
      e_prev = e;
    end
  end

  function automatic void model_char(input logic [7:0] b);
    if (m_cnt == 16) begin
      exp_rs.push_back(1'b0); exp_d.push_back(8'hC0);
    end else if (m_cnt == 0 && m_wrap) begin
      exp_rs.push_back(1'b0); exp_d.push_back(8'h80);
    end
    exp_rs.push_back(1'b1); exp_d.push_back(b);
    m_cnt = (m_cnt + 1) % 32;
    if (m_cnt == 0) m_wrap = 1;
  endfunction

  function automatic void model_init();
`ifdef WRITE_LCD_INIT_EN
    logic [7:0] ic[4] = '{8'h38, 8'h0C, 8'h01, 8'h06};
    foreach (ic[i]) begin
      exp_rs.push_back(1'b0); exp_d.push_back(ic[i]);
    end
`endif
  endfunction

  task automatic press(input logic [7:0] b, input int hold,
                       output int pc);
    @(posedge clk); #2;
    dbtn = b; prell = 1'b1; pc = cyc;
    repeat (hold) @(posedge clk);
    #2 prell = 1'b0;
  endtask

  task automatic wait_writes(input int n, input int budget,
                             output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (obs.size() >= n) begin ok = 1; break; end
      @(negedge clk);
    end
    if (obs.size() >= n) ok = 1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; prell = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (e !== 1'b0) begin bad++;
      $display("FAIL reset_e: got %b want 0", e); end
    total++;
    if (rs !== 1'b0) begin bad++;
      $display("FAIL reset_rs: got %b want 0", rs); end
    total++;
    if (rw !== 1'b0) begin bad++;
      $display("FAIL reset_rw: got %b want 0", rw); end
    total++;
    if (dout !== 8'h00) begin bad++;
      $display("FAIL reset_data: got %h want 00", dout); end
    @(posedge clk); #2;
    reset_n = 1'b1; rel_cyc = cyc;
  endtask

  task automatic test_init();
`ifdef WRITE_LCD_INIT_EN
    logic [7:0] ic[4] = '{8'h38, 8'h0C, 8'h01, 8'h06};
    bit ok;
    wait_writes(4, 1500, ok);
    total++;
    if (!ok) begin bad++;
      $display("FAIL init_timeout: got %0d writes want 4", obs.size());
    end else begin
      foreach (ic[i]) begin
        total++;
        if (obs[i].d !== ic[i] || obs[i].rs !== 1'b0) begin bad++;
          $display("FAIL init_cmd%0d: got rs=%b %h want rs=0 %h",
                   i, obs[i].rs, obs[i].d, ic[i]);
        end
      end
      total++;
      if (obs[0].rise - rel_cyc != TP + 3) begin bad++;
        $display("FAIL powerup_delay: got %0d want %0d",
                 obs[0].rise - rel_cyc, TP + 3);
      end
      total++;
      if (obs[2].rise - obs[1].fall != TH + TX + TS) begin bad++;
        $display("FAIL exec_gap: got %0d want %0d",
                 obs[2].rise - obs[1].fall, TH + TX + TS);
      end
      total++;
      if (obs[3].rise - obs[2].fall != TH + TC + TS) begin bad++;
        $display("FAIL clear_gap: got %0d want %0d",
                 obs[3].rise - obs[2].fall, TH + TC + TS);
      end
    end
    repeat (TX + 10) @(negedge clk);
`else
    repeat (10) @(negedge clk);
    total++;
    if (obs.size() != 0 || e !== 1'b0) begin bad++;
      $display("FAIL no_init_writes: got %0d writes want 0",
               obs.size());
    end
`endif
    model_init();
  endtask

  task automatic test_single();
    int n0, pc;
    bit ok;
    n0 = obs.size();
    press(8'h8C, 200, pc);
    wait_writes(n0 + 1, 50, ok);
    total++;
    if (!ok) begin bad++;
      $display("FAIL single_timeout: got %0d writes want %0d",
               obs.size(), n0 + 1);
    end else begin
      total++;
      if (obs[n0].rs !== 1'b1 || obs[n0].d !== 8'h8C) begin bad++;
        $display("FAIL single_data: got rs=%b %h want rs=1 8c",
                 obs[n0].rs, obs[n0].d);
      end
      total++;
      if (obs[n0].rise - pc != 4 || obs[n0].setup != TS) begin bad++;
        $display("FAIL single_latency: got %0d/%0d want 4/%0d",
                 obs[n0].rise - pc, obs[n0].setup, TS);
      end
      total++;
      if (obs[n0].width != TE) begin bad++;
        $display("FAIL single_epw: got %0d want %0d",
                 obs[n0].width, TE);
      end
    end
    repeat (50) @(negedge clk);
    total++;
    if (obs.size() != n0 + 1) begin bad++;
      $display("FAIL held_button: got %0d writes want %0d",
               obs.size(), n0 + 1);
    end
    model_char(8'h8C);
  endtask

  task automatic test_back_to_back();
    int n0, p1, p2, p3;
    bit ok;
    n0 = obs.size();
    press(8'h41, 2, p1);
    while (cyc < p1 + 22) @(posedge clk);
    press(8'h42, 2, p2);
    press(8'h43, 2, p3);
    wait_writes(n0 + 2, 200, ok);
    repeat (100) @(negedge clk);
    total++;
    if (!ok || obs.size() != n0 + 2) begin bad++;
      $display("FAIL pending_count: got %0d writes want %0d",
               obs.size(), n0 + 2);
    end else begin
      total++;
      if (obs[n0].d !== 8'h41 || obs[n0 + 1].d !== 8'h42) begin bad++;
        $display("FAIL pending_data: got %h %h want 41 42",
                 obs[n0].d, obs[n0 + 1].d);
      end
      total++;
      if (obs[n0 + 1].rise - obs[n0].fall != TH + TX + TS) begin bad++;
        $display("FAIL pending_gap: got %0d want %0d",
                 obs[n0 + 1].rise - obs[n0].fall, TH + TX + TS);
      end
    end
    model_char(8'h41);
    model_char(8'h42);
  endtask

  task automatic test_cursor_wrap();
    int pc, nchar;
    logic [7:0] b;
    for (int k = 0; k < 32; k++) begin
      b = 8'($urandom);
      press(b, $urandom_range(1, 4), pc);
      model_char(b);
      repeat (95) @(posedge clk);
    end
    nchar = 0;
    for (int i = 0; i < obs.size(); i++) begin
      if (obs[i].rs === 1'b1) begin
        nchar++;
        if (nchar == 17 || nchar == 33) begin
          total++;
          if (i == 0 || obs[i - 1].rs !== 1'b0 ||
              obs[i - 1].d !== (nchar == 17 ? 8'hC0 : 8'h80)) begin
            bad++;
            $display("FAIL addr_before_char%0d: got %h want %h",
                     nchar, i > 0 ? obs[i - 1].d : 8'hxx,
                     nchar == 17 ? 8'hC0 : 8'h80);
          end
        end
      end
    end
    total++;
    if (nchar != 35) begin bad++;
      $display("FAIL char_count: got %0d want 35", nchar);
    end
  endtask

  task automatic test_log();
    int n, w;
    total++;
    if (obs.size() != exp_d.size()) begin bad++;
      $display("FAIL log_len: got %0d want %0d",
               obs.size(), exp_d.size());
    end
    n = obs.size() < exp_d.size() ? obs.size() : exp_d.size();
    for (int i = 0; i < n; i++) begin
      total++;
      if (obs[i].rs !== exp_rs[i] || obs[i].d !== exp_d[i]) begin
        bad++;
        $display("FAIL log_entry%0d: got rs=%b %h want rs=%b %h", i,
                 obs[i].rs, obs[i].d, exp_rs[i], exp_d[i]);
      end
      total++;
      if (obs[i].width != TE || obs[i].setup < TS) begin bad++;
        $display("FAIL log_timing%0d: got epw=%0d su=%0d want %0d/>=%0d",
                 i, obs[i].width, obs[i].setup, TE, TS);
      end
      if (i > 0) begin
        w = (!exp_rs[i - 1] && exp_d[i - 1] == 8'h01) ? TC : TX;
        total++;
        if (obs[i].rise - obs[i - 1].fall < TH + w + TS) begin bad++;
          $display("FAIL log_gap%0d: got %0d want >=%0d", i,
                   obs[i].rise - obs[i - 1].fall, TH + w + TS);
        end
      end
    end
    total++;
    if (prot_err != 0) begin bad++;
      $display("FAIL bus_protocol: got %0d violations want 0", prot_err);
    end
  endtask

  task automatic test_reset_mid();
    int pc, nexp, k;
    bit ok;
    press(8'h5A, 2, pc);
    k = 0;
    while (e !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    total++;
    if (e !== 1'b1) begin bad++;
      $display("FAIL mid_ehigh_timeout: got e=%b want 1", e);
    end
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (e !== 1'b0 || dout !== 8'h00 || rs !== 1'b0) begin bad++;
      $display("FAIL async_reset: got e=%b rs=%b %h want 0 0 00",
               e, rs, dout);
    end
    repeat (3) @(posedge clk);
    #2;
    obs.delete(); exp_rs.delete(); exp_d.delete();
    m_cnt = 0; m_wrap = 0;
    reset_n = 1'b1; rel_cyc = cyc;
    test_init();
    press(8'h55, 2, pc);
    model_char(8'h55);
    nexp = exp_d.size();
    wait_writes(nexp, 200, ok);
    repeat (60) @(negedge clk);
    total++;
    if (!ok || obs.size() != nexp) begin bad++;
      $display("FAIL post_reset_count: got %0d want %0d",
               obs.size(), nexp);
    end else begin
      total++;
      if (obs[nexp - 1].rs !== 1'b1 || obs[nexp - 1].d !== 8'h55) begin
        bad++;
        $display("FAIL post_reset_char: got rs=%b %h want rs=1 55",
                 obs[nexp - 1].rs, obs[nexp - 1].d);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_init();
    test_single();
    test_back_to_back();
    test_cursor_wrap();
    test_log();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
